// File: rtl/buffer_id_pkg.sv
// Double-buffer identifiers shared by the geometry tables and the framebuffer pair.
package buffer_id_pkg;

    typedef logic [0:0] buf_id_t;

    localparam buf_id_t BUF_A = 1'b0;
    localparam buf_id_t BUF_B = 1'b1;

endpackage

// File: rtl/sched_pkg.sv
// Frame sequencer state encoding.
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        RENDER,
        DRAIN,
        WAIT_VSYNC,
        SWAP
    } sched_state_t;

endpackage

// File: rtl/frame_watchdog.sv
// Cycle watchdog for the RENDER+DRAIN window; expire_c fires on the last allowed cycle.
module frame_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 2**22
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WD_W'(1);
        end
    end

    assign expire_c = enable && (count == WD_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: arms frame_driver, waits for draw + raster drain, and swaps
// geometry tables on SPI commit and framebuffers on vsync.
module frame_scheduler
    import buffer_id_pkg::*;
    import sched_pkg::*;
#(
    parameter int unsigned INST_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 2**22,
    parameter int unsigned DRAIN_MIN   = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_commit,
    input  logic [INST_W-1:0] spi_max_inst,
    input  logic              vsync,
    input  logic              draw_done,
    input  logic              raster_idle,
    output logic              render_en,
    output logic [INST_W-1:0] max_inst,
    output buf_id_t           geom_rd_buf,
    output buf_id_t           geom_wr_buf,
    output logic              commit_pending,
    output buf_id_t           fb_draw_buf,
    output buf_id_t           fb_disp_buf,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              timeout_err
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_MIN + 1);

    sched_state_t       state, state_next;
    logic [DRAIN_W-1:0] drain_cnt, drain_cnt_next;
    logic [INST_W-1:0]  pend_inst, pend_inst_next, max_inst_next;
    logic               commit_pending_next, render_en_next, timeout_err_next;
    buf_id_t            geom_rd_next, fb_draw_next;
    logic [CNT_W-1:0]   frame_count_next, drop_count_next;
    logic               wd_enable, wd_clear, wd_expire_c;

    frame_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .expire_c (wd_expire_c)
    );

    assign wd_enable   = (state == RENDER) || (state == DRAIN);
    assign wd_clear    = (state_next == WAIT_VSYNC) && (state != WAIT_VSYNC);
    assign geom_wr_buf = ~geom_rd_buf;
    assign fb_disp_buf = ~fb_draw_buf;

    always_comb begin
        state_next          = state;
        drain_cnt_next      = '0;
        pend_inst_next      = pend_inst;
        commit_pending_next = commit_pending;
        max_inst_next       = max_inst;
        geom_rd_next        = geom_rd_buf;
        fb_draw_next        = fb_draw_buf;
        frame_count_next    = frame_count;
        drop_count_next     = drop_count;
        timeout_err_next    = timeout_err;

        case (state)
            IDLE: state_next = LATCH;
            LATCH: begin
                if (commit_pending) begin
                    geom_rd_next        = ~geom_rd_buf;
                    max_inst_next       = pend_inst;
                    commit_pending_next = 1'b0;
                end
                state_next = RENDER;
            end
            RENDER: begin
                if (wd_expire_c) begin
                    timeout_err_next = 1'b1;
                    state_next       = WAIT_VSYNC;
                end else if (draw_done) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (wd_expire_c) begin
                    timeout_err_next = 1'b1;
                    state_next       = WAIT_VSYNC;
                end else if (raster_idle) begin
                    if (drain_cnt == DRAIN_W'(DRAIN_MIN - 1)) begin
                        state_next = WAIT_VSYNC;
                    end else begin
                        drain_cnt_next = drain_cnt + DRAIN_W'(1);
                    end
                end
            end
            WAIT_VSYNC: if (vsync) state_next = SWAP;
            SWAP: begin
                fb_draw_next     = ~fb_draw_buf;
                frame_count_next = frame_count + CNT_W'(1);
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A commit landing on LATCH overrides the value just consumed and waits a frame.
        if (spi_commit) begin
            commit_pending_next = 1'b1;
            pend_inst_next      = spi_max_inst;
        end

        if (vsync && (state != WAIT_VSYNC)) begin
            drop_count_next = drop_count + CNT_W'(1);
        end

        render_en_next = (state_next == RENDER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            pend_inst      <= '0;
            commit_pending <= 1'b0;
            max_inst       <= '0;
            geom_rd_buf    <= BUF_A;
            fb_draw_buf    <= BUF_A;
            frame_count    <= '0;
            drop_count     <= '0;
            timeout_err    <= 1'b0;
            render_en      <= 1'b0;
        end else begin
            state          <= state_next;
            drain_cnt      <= drain_cnt_next;
            pend_inst      <= pend_inst_next;
            commit_pending <= commit_pending_next;
            max_inst       <= max_inst_next;
            geom_rd_buf    <= geom_rd_next;
            fb_draw_buf    <= fb_draw_next;
            frame_count    <= frame_count_next;
            drop_count     <= drop_count_next;
            timeout_err    <= timeout_err_next;
            render_en      <= render_en_next;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: cycle vector table, randomized frames against a
// frame-level model, and directed coalesce / drop / watchdog sequences.
module tb_frame_scheduler;

    localparam int DRAIN_MIN = 4;
    localparam int TIMEOUT   = 64;
    localparam int NV        = 21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_commit = 1'b0;
    logic [7:0]  spi_max_inst = 8'd0;
    logic        vsync = 1'b0;
    logic        draw_done = 1'b0;
    logic        raster_idle = 1'b0;
    logic        render_en;
    logic [7:0]  max_inst;
    logic [0:0]  geom_rd_buf, geom_wr_buf, fb_draw_buf, fb_disp_buf;
    logic        commit_pending;
    logic [15:0] frame_count, drop_count;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model state
    logic        m_pend = 1'b0;
    logic [7:0]  m_pval = 8'd0;
    logic [7:0]  m_max = 8'd0;
    logic        m_geom = 1'b0;
    logic        m_fb = 1'b0;
    logic        m_timeout = 1'b0;
    logic [15:0] m_fc = 16'd0;
    logic [15:0] m_drop = 16'd0;

    typedef struct packed {
        logic        rst, cm;
        logic [7:0]  inst;
        logic        vs, dd, idle;
        logic        ren, pend;
        logic [7:0]  max;
        logic        geom, fb;
        logic [15:0] fc, drop;
    } vec_t;

    vec_t tbl [NV];

    frame_scheduler #(
        .INST_W(8), .TIMEOUT_CYC(TIMEOUT), .DRAIN_MIN(DRAIN_MIN), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .spi_commit(spi_commit), .spi_max_inst(spi_max_inst),
        .vsync(vsync), .draw_done(draw_done), .raster_idle(raster_idle),
        .render_en(render_en), .max_inst(max_inst), .geom_rd_buf(geom_rd_buf),
        .geom_wr_buf(geom_wr_buf), .commit_pending(commit_pending),
        .fb_draw_buf(fb_draw_buf), .fb_disp_buf(fb_disp_buf),
        .frame_count(frame_count), .drop_count(drop_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    function automatic vec_t mk(input int r, input int cm, input int inst, input int vs,
                                input int dd, input int idle, input int ren, input int pend,
                                input int mx, input int geom, input int fb, input int fc,
                                input int drop);
        vec_t v;
        v.rst = 1'(r);      v.cm = 1'(cm);    v.inst = 8'(inst);
        v.vs = 1'(vs);      v.dd = 1'(dd);    v.idle = 1'(idle);
        v.ren = 1'(ren);    v.pend = 1'(pend); v.max = 8'(mx);
        v.geom = 1'(geom);  v.fb = 1'(fb);    v.fc = 16'(fc);
        v.drop = 16'(drop);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic dd, input logic idle,
                         input logic cm, input logic [7:0] inst);
        vsync = vs; draw_done = dd; raster_idle = idle;
        spi_commit = cm; spi_max_inst = inst;
        step();
        vsync = 1'b0; draw_done = 1'b0; spi_commit = 1'b0;
    endtask

    task automatic wait_render();
        for (int i = 0; i < 12 && render_en !== 1'b1; i++) step();
        chk("render_rise", 32'(render_en), 32'(1));
    endtask

    // Pending commit is applied on the LATCH cycle just before render_en rises.
    task automatic latch_check();
        logic g_wr;
        if (m_pend) begin
            m_geom = ~m_geom;
            m_max  = m_pval;
            m_pend = 1'b0;
        end
        g_wr = ~m_geom;
        chk("latch_max_inst", 32'(max_inst), 32'(m_max));
        chk("latch_geom_rd", 32'(geom_rd_buf), 32'(m_geom));
        chk("latch_geom_wr", 32'(geom_wr_buf), 32'(g_wr));
        chk("latch_commit_pending", 32'(commit_pending), 32'(m_pend));
    endtask

    task automatic vsync_swap();
        logic d;
        d = ~m_fb;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("swap_lat_draw", 32'(fb_draw_buf), 32'(m_fb));
        chk("swap_lat_disp", 32'(fb_disp_buf), 32'(d));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        m_fb = ~m_fb;
        m_fc = m_fc + 16'd1;
        d = ~m_fb;
        chk("swap_fb_draw", 32'(fb_draw_buf), 32'(m_fb));
        chk("swap_fb_disp", 32'(fb_disp_buf), 32'(d));
        chk("swap_frame_count", 32'(frame_count), 32'(m_fc));
        chk("swap_drop_count", 32'(drop_count), 32'(m_drop));
        chk("swap_timeout_err", 32'(timeout_err), 32'(m_timeout));
    endtask

    task automatic finish_frame();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        chk("draw_done_stops_render", 32'(render_en), 32'(0));
        repeat (DRAIN_MIN + 2) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        vsync_swap();
    endtask

    task automatic rand_frame();
        int         len, pre, run, n, slack;
        logic       vs, cm, dd, b;
        logic [7:0] v;
        wait_render();
        latch_check();
        len = int'($urandom_range(1, 30));
        for (int i = 0; i < len - 1; i++) begin
            vs = ($urandom_range(0, 5) == 0);
            cm = ($urandom_range(0, 4) == 0);
            v  = 8'($urandom);
            if (vs) m_drop = m_drop + 16'd1;
            if (cm) begin m_pend = 1'b1; m_pval = v; end
            drive(vs, 1'b0, 1'($urandom), cm, v);
            chk("render_hold", 32'(render_en), 32'(1));
            if (cm) chk("commit_pending_set", 32'(commit_pending), 32'(1));
        end
        vs = ($urandom_range(0, 3) == 0);
        if (vs) m_drop = m_drop + 16'd1;
        drive(vs, 1'b1, 1'b1, 1'b0, 8'd0);
        chk("render_off_after_done", 32'(render_en), 32'(0));
        // Drain ends on the cycle that completes DRAIN_MIN consecutive idle samples.
        pre = int'($urandom_range(0, 6));
        run = 0;
        n   = 0;
        while (run < DRAIN_MIN) begin
            b  = (n < pre) ? 1'($urandom) : 1'b1;
            vs = ($urandom_range(0, 4) == 0);
            cm = ($urandom_range(0, 5) == 0);
            dd = ($urandom_range(0, 5) == 0);
            v  = 8'($urandom);
            if (vs) m_drop = m_drop + 16'd1;
            if (cm) begin m_pend = 1'b1; m_pval = v; end
            drive(vs, dd, b, cm, v);
            chk("drain_render_off", 32'(render_en), 32'(0));
            run = b ? run + 1 : 0;
            n++;
        end
        slack = int'($urandom_range(0, 5));
        for (int i = 0; i < slack; i++) begin
            cm = ($urandom_range(0, 3) == 0);
            v  = 8'($urandom);
            if (cm) begin m_pend = 1'b1; m_pval = v; end
            drive(1'b0, 1'($urandom), 1'($urandom), cm, v);
        end
        chk("wait_drop_count", 32'(drop_count), 32'(m_drop));
        vsync_swap();
    endtask

    initial begin
        logic        g_wr;
        logic [7:0]  exp_max;
        logic        exp_geom;
        logic [15:0] d0;

        tbl[0]  = mk(1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
        tbl[1]  = mk(0,1,9, 0,0,0, 0,1,0, 0,0,0,0);
        tbl[2]  = mk(0,1,12,0,0,0, 1,1,9, 1,0,0,0);
        tbl[3]  = mk(0,0,0, 1,0,0, 1,1,9, 1,0,0,1);
        tbl[4]  = mk(0,0,0, 1,1,0, 0,1,9, 1,0,0,2);
        tbl[5]  = mk(0,0,0, 0,0,1, 0,1,9, 1,0,0,2);
        tbl[6]  = mk(0,0,0, 0,0,1, 0,1,9, 1,0,0,2);
        tbl[7]  = mk(0,0,0, 0,0,0, 0,1,9, 1,0,0,2);
        tbl[8]  = mk(0,0,0, 0,0,1, 0,1,9, 1,0,0,2);
        tbl[9]  = mk(0,0,0, 0,0,1, 0,1,9, 1,0,0,2);
        tbl[10] = mk(0,0,0, 0,0,1, 0,1,9, 1,0,0,2);
        tbl[11] = mk(0,0,0, 1,0,1, 0,1,9, 1,0,0,3);
        tbl[12] = mk(0,0,0, 1,0,1, 0,1,9, 1,0,0,3);
        tbl[13] = mk(0,0,0, 0,0,1, 0,1,9, 1,1,1,3);
        tbl[14] = mk(0,0,0, 0,0,1, 0,1,9, 1,1,1,3);
        tbl[15] = mk(0,0,0, 0,0,1, 1,0,12,0,1,1,3);
        tbl[16] = mk(0,1,0, 0,0,1, 1,1,12,0,1,1,3);
        tbl[17] = mk(0,0,0, 0,1,1, 0,1,12,0,1,1,3);
        tbl[18] = mk(1,0,0, 0,0,1, 0,0,0, 0,0,0,0);
        tbl[19] = mk(0,0,0, 0,0,1, 0,0,0, 0,0,0,0);
        tbl[20] = mk(0,0,0, 0,0,1, 1,0,0, 0,0,0,0);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; spi_commit = tbl[i].cm; spi_max_inst = tbl[i].inst;
            vsync = tbl[i].vs; draw_done = tbl[i].dd; raster_idle = tbl[i].idle;
            step();
            g_wr = ~tbl[i].geom;
            chk($sformatf("tbl%0d_render_en", i), 32'(render_en), 32'(tbl[i].ren));
            chk($sformatf("tbl%0d_commit_pending", i), 32'(commit_pending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_max_inst", i), 32'(max_inst), 32'(tbl[i].max));
            chk($sformatf("tbl%0d_geom_rd", i), 32'(geom_rd_buf), 32'(tbl[i].geom));
            chk($sformatf("tbl%0d_geom_wr", i), 32'(geom_wr_buf), 32'(g_wr));
            chk($sformatf("tbl%0d_fb_draw", i), 32'(fb_draw_buf), 32'(tbl[i].fb));
            chk($sformatf("tbl%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].fc));
            chk($sformatf("tbl%0d_drop_count", i), 32'(drop_count), 32'(tbl[i].drop));
            chk($sformatf("tbl%0d_timeout_err", i), 32'(timeout_err), 32'(0));
        end
        spi_commit = 1'b0; vsync = 1'b0; draw_done = 1'b0;

        for (int f = 0; f < 40; f++) rand_frame();

        // Two commits before one LATCH: single table toggle, newest count wins.
        wait_render();
        latch_check();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd7);
        m_pend = 1'b1; m_pval = 8'd7;
        exp_geom = ~m_geom;
        finish_frame();
        wait_render();
        exp_max = 8'd7;
        chk("coalesce_max_inst", 32'(max_inst), 32'(exp_max));
        chk("coalesce_geom_rd", 32'(geom_rd_buf), 32'(exp_geom));
        latch_check();

        // Three vsyncs while rendering are all drops; display buffer holds.
        d0 = m_drop;
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        m_drop = m_drop + 16'd3;
        g_wr = ~m_fb;
        chk("drops_disp_hold", 32'(fb_disp_buf), 32'(g_wr));
        chk("drops_count3", 32'(drop_count), 32'(d0 + 16'd3));
        finish_frame();

        // Watchdog: withhold draw_done until the RENDER window expires.
        wait_render();
        latch_check();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            chk("wd_render_hold", 32'(render_en), 32'(1));
        end
        chk("wd_no_early_err", 32'(timeout_err), 32'(0));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        m_timeout = 1'b1;
        chk("wd_render_off", 32'(render_en), 32'(0));
        chk("wd_timeout_err", 32'(timeout_err), 32'(1));
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        vsync_swap();
        rand_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
